ehgu_hamming_scrub_ctrl: RTL and testbench
==========================================

// Module: ehgu_hamming_scrub_ctrl
// PURPOSE
// Background scrubber for a Hamming SECDED-protected word memory.
// - On start: sweeps addresses 0..DEPTH-1 via a shared req/gnt memory port.
// - Decodes each word, writes back single-bit corrections, logs double-bit errors.
// - Acts as a low-priority requester beside the functional encode/decode path.
// PARAMETERS
// N     7   Hamming code length (positions 1..N); codeword is N+1 bits, bit N = overall parity
// K     4   data bits; parity bit j sits at index (2**j)-1, for j < N-K
// DEPTH 16  words to scrub; AW = $clog2(DEPTH)
// CW    8   width of the saturating error counters
// PORTS
// clk          in   1      clock
// rst_n        in   1      synchronous active-low reset
// start        in   1      1-cycle pulse; ignored unless idle
// abort        in   1      level; ends the sweep early
// mem_req      out  1      memory request; held until mem_gnt
// mem_we       out  1      1 = write-back, 0 = read
// mem_addr     out  AW     word address
// mem_wdata    out  N+1    corrected codeword
// mem_gnt      in   1      request accepted this cycle
// mem_rvalid   in   1      read data valid; >=1 cycle after read gnt
// mem_rdata    in   N+1    read codeword
// busy         out  1      sweep in progress
// done         out  1      1-cycle pulse at sweep end or abort
// corr_cnt     out  CW     corrected-error count, saturating
// uncorr_cnt   out  CW     uncorrectable-error count, saturating
// err_valid    out  1      1-cycle pulse on uncorrectable word
// err_addr     out  AW     address of last uncorrectable word, held until next one
// BEHAVIOUR
// Reset: state IDLE; all outputs 0; internal address 0.
// FSM states: IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT, DONE.
// - IDLE: on start -> RD_REQ. Clear both counters and address in the same cycle.
// - RD_REQ: mem_req=1, mem_we=0. On mem_gnt -> RD_WAIT. If abort is seen before gnt -> DONE, no request issued.
// - RD_WAIT: capture mem_rdata when mem_rvalid -> CHECK. abort is honoured only after data returns.
// - CHECK (1 cycle): compute syndrome s (N-K bits) and overall parity p.
//   - s[j] = XOR of rdata[i] over all i<N where bit j of (i+1) is 1. p = XOR of all N+1 bits.
//   - s==0, p==0: clean -> NEXT.
//   - p==1: single error; flip bit s-1 (bit N if s==0); corr_cnt++ -> WR_REQ. If s>N: treat as uncorrectable.
//   - s!=0, p==0: double error; uncorr_cnt++, err_valid=1, err_addr=addr -> NEXT, no write.
//   - abort pending: skip the write, still count, -> DONE.
// - WR_REQ: mem_req=1, mem_we=1, mem_wdata = corrected word. Hold stable until mem_gnt -> NEXT.
// - NEXT: if addr==DEPTH-1 or abort -> DONE; else addr++ -> RD_REQ.
// - DONE: done=1 for 1 cycle -> IDLE.
// busy = (state != IDLE).
// mem_addr/mem_we/mem_wdata stay stable while mem_req=1 and no gnt.
// Counters stop at 2**CW-1.
// Read-to-read minimum is 4 cycles (RD_REQ, RD_WAIT, CHECK, NEXT) with 1-cycle gnt/rvalid.
// rst_n low mid-sweep: back to IDLE next edge; outstanding read data is dropped.
// start while busy: ignored.
// TESTING
// Clean word: every word = 8'h55 (data 4'b1011) -> no writes; DEPTH reads; done after last read; counters 0.
// Single error at addr 3: word 8'h51 (bit 2 flipped) -> write 8'h55 to addr 3; corr_cnt=1.
// Overall-parity error: word 8'hD5 at addr 5 -> write 8'h55; corr_cnt=1.
// Double error: word 8'h56 at addr 9 -> no write; err_valid pulse; err_addr=9; uncorr_cnt=1.
// Backpressure: mem_gnt low for 5 cycles -> req/addr/we/wdata stable; sweep completes.
// Abort in RD_WAIT at addr 6 -> CHECK runs, no write, done pulse, IDLE; reset mid-WR_REQ -> all outputs 0.

Source files
------------

// File: rtl/ehgu_hamming_scrub_ctrl.sv
// Background scrubber for a SECDED Hamming word memory: sweeps every address over a
// shared req/gnt port, writes back single-bit corrections and logs double-bit errors.
module ehgu_hamming_scrub_ctrl #(
  parameter int N     = 7,
  parameter int K     = 4,
  parameter int DEPTH = 16,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [$clog2(DEPTH)-1:0] mem_addr,
  output logic [N:0]               mem_wdata,
  input  logic                     mem_gnt,
  input  logic                     mem_rvalid,
  input  logic [N:0]               mem_rdata,
  output logic                     busy,
  output logic                     done,
  output logic [CW-1:0]            corr_cnt,
  output logic [CW-1:0]            uncorr_cnt,
  output logic                     err_valid,
  output logic [$clog2(DEPTH)-1:0] err_addr,
  output logic [2:0]               state_dbg
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = N - K;

  // Handshake: a request (read or write) is accepted on the cycle mem_req and
  // mem_gnt are both high; until then mem_addr/mem_we/mem_wdata hold steady.
  // Read data is taken on any cycle mem_rvalid is high while waiting for it.
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic [N:0]    rd_word, fix_word, corr_word;
  logic [PW-1:0] syn;
  logic          par, single_err, double_err;
  logic          abort_pend, abort_any, last_addr;
  int            syn_val, flip_idx;

  assign abort_any = abort | abort_pend;
  assign last_addr = (addr == AW'(DEPTH - 1));

  // Syndrome bit j covers every Hamming position (i+1) that has bit j set.
  always_comb begin
    syn = '0;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < PW; j++)
        if ((((i + 1) >> j) & 1) == 1) syn[j] = syn[j] ^ rd_word[i];
    par        = ^rd_word;
    syn_val    = {{(32 - PW){1'b0}}, syn};
    flip_idx   = (syn_val == 0) ? N : syn_val - 1;
    for (int i = 0; i <= N; i++) fix_word[i] = rd_word[i] ^ (i == flip_idx);
    single_err = par && (syn_val <= N);
    double_err = (!par && (syn_val != 0)) || (par && (syn_val > N));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RD_REQ;
      RD_REQ:  if (mem_gnt) state_nxt = RD_WAIT;
               else if (abort_any) state_nxt = DONE;
      RD_WAIT: if (mem_rvalid) state_nxt = CHECK;
      CHECK:   if (abort_any) state_nxt = DONE;
               else if (single_err) state_nxt = WR_REQ;
               else state_nxt = NEXT;
      WR_REQ:  if (mem_gnt) state_nxt = NEXT;
      NEXT:    state_nxt = (last_addr || abort_any) ? DONE : RD_REQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_req   = (state == RD_REQ) || (state == WR_REQ);
    mem_we    = (state == WR_REQ);
    mem_addr  = addr;
    mem_wdata = corr_word;
    busy      = (state != IDLE);
    done      = (state == DONE);
    state_dbg = state;
  end

  // Errors are still counted in CHECK when an abort suppresses the write-back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr       <= '0;
      rd_word    <= '0;
      corr_word  <= '0;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
      err_valid  <= 1'b0;
      err_addr   <= '0;
      abort_pend <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      if (state == IDLE) abort_pend <= 1'b0;
      else if (abort)    abort_pend <= 1'b1;
      case (state)
        IDLE: if (start) begin
          addr       <= '0;
          corr_cnt   <= '0;
          uncorr_cnt <= '0;
        end
        RD_WAIT: if (mem_rvalid) rd_word <= mem_rdata;
        CHECK: begin
          if (single_err) begin
            corr_word <= fix_word;
            if (corr_cnt != '1) corr_cnt <= corr_cnt + 1'b1;
          end
          if (double_err) begin
            err_valid <= 1'b1;
            err_addr  <= addr;
            if (uncorr_cnt != '1) uncorr_cnt <= uncorr_cnt + 1'b1;
          end
        end
        NEXT: if (!last_addr && !abort_any) addr <= addr + 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ehgu_hamming_scrub_ctrl.sv
// Bench for the Hamming scrubber: a small memory responder with stall control, a
// write-back scoreboard, a table of single-sweep vectors and hand-written corner cases.
module tb_ehgu_hamming_scrub_ctrl;
  localparam int N = 7, K = 4, DEPTH = 16, AW = 4;
  localparam int CW = 4;  // narrow counters so saturation is reachable in one sweep

  logic          clk = 0, rst_n = 0, start = 0, abort = 0;
  logic          mem_req, mem_we, mem_gnt = 0, mem_rvalid = 0;
  logic [AW-1:0] mem_addr, err_addr;
  logic [N:0]    mem_wdata, mem_rdata = '0;
  logic          busy, done, err_valid;
  logic [CW-1:0] corr_cnt, uncorr_cnt;
  logic [2:0]    state_dbg;

  ehgu_hamming_scrub_ctrl #(.N(N), .K(K), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt),
    .err_valid(err_valid), .err_addr(err_addr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    bg;
    logic [AW-1:0] bad_addr;
    logic [7:0]    bad_word;
    logic          exp_wr;
    logic [7:0]    exp_wdata;
    logic [CW-1:0] exp_corr;
    logic [CW-1:0] exp_uncorr;
    int            exp_pulses;
    logic [AW-1:0] exp_err_addr;
  } vec_t;

  logic [AW+7:0] exp_q[$];
  logic [7:0]    mem [DEPTH];
  int            n_vec = 0, n_err = 0;
  int            rd_cnt = 0, wr_cnt = 0, err_pulses = 0;
  int            stall_rd = 0, stall_wr = 0;
  bit            rd_pend = 0, stalling = 0;
  logic [AW-1:0] rd_pend_addr = '0, last_rd_addr = '0, snap_addr = '0;
  logic [7:0]    snap_wdata = '0;
  logic          snap_we = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: drives gnt/rvalid on the falling edge, 1-cycle read latency.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_gnt = 0; mem_rvalid = 0; rd_pend = 0; stalling = 0;
      end else begin
        mem_rvalid = rd_pend;
        mem_rdata  = rd_pend ? mem[rd_pend_addr] : '0;
        rd_pend    = 0;
        if (err_valid) err_pulses++;
        mem_gnt = 0;
        if (!mem_req) stalling = 0;
        else if ((mem_we && stall_wr > 0) || (!mem_we && stall_rd > 0)) begin
          if (stalling) begin
            check("stall_addr", mem_addr, snap_addr);
            check("stall_we", mem_we, snap_we);
            if (snap_we) check("stall_wdata", mem_wdata, snap_wdata);
          end
          snap_addr = mem_addr; snap_we = mem_we; snap_wdata = mem_wdata;
          stalling = 1;
          if (mem_we) stall_wr--; else stall_rd--;
        end else begin
          stalling = 0;
          mem_gnt  = 1;
          if (mem_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) check("unexpected_write", {mem_addr, mem_wdata}, 32'hFFFF);
            else check("write_back", {mem_addr, mem_wdata}, exp_q.pop_front());
            mem[mem_addr] = mem_wdata;
          end else begin
            rd_cnt++;
            rd_pend = 1; rd_pend_addr = mem_addr; last_rd_addr = mem_addr;
          end
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, ".req"}, mem_req, 0);
    check({tag, ".we"}, mem_we, 0);
    check({tag, ".addr"}, mem_addr, 0);
    check({tag, ".wdata"}, mem_wdata, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".corr"}, corr_cnt, 0);
    check({tag, ".uncorr"}, uncorr_cnt, 0);
    check({tag, ".err_valid"}, err_valid, 0);
    check({tag, ".err_addr"}, err_addr, 0);
  endtask

  task automatic load_mem(input logic [7:0] bg, input logic [AW-1:0] a, input logic [7:0] w);
    for (int i = 0; i < DEPTH; i++) mem[i] = bg;
    mem[a] = w;
    exp_q.delete();
    rd_cnt = 0; wr_cnt = 0; err_pulses = 0;
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    check({tag, ".busy_after_start"}, busy, 1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin seen = 1; break; end
    end
    check({tag, ".done_seen"}, seen, 1);
    if (seen) begin
      @(negedge clk);
      check({tag, ".done_pulse"}, done, 0);
      check({tag, ".idle"}, busy, 0);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string tag = $sformatf("vec%0d", idx);
    load_mem(v.bg, v.bad_addr, v.bad_word);
    if (v.exp_wr) exp_q.push_back({v.bad_addr, v.exp_wdata});
    pulse_start(tag);
    wait_done(tag, 400);
    check({tag, ".reads"}, rd_cnt, DEPTH);
    check({tag, ".pending_writes"}, exp_q.size(), 0);
    check({tag, ".corr"}, corr_cnt, v.exp_corr);
    check({tag, ".uncorr"}, uncorr_cnt, v.exp_uncorr);
    check({tag, ".err_pulses"}, err_pulses, v.exp_pulses);
    if (v.exp_uncorr != 0) check({tag, ".err_addr"}, err_addr, v.exp_err_addr);
    check({tag, ".mem_after"}, mem[v.bad_addr], v.exp_wr ? v.exp_wdata : v.bad_word);
  endtask

  vec_t vecs[11];
  bit   hit;

  initial begin
    //             bg     addr   word   wr    wdata  corr  unc   pulses erraddr
    vecs[0]  = '{8'h55, 4'd0,  8'h55, 1'b0, 8'h00, 4'd0, 4'd0, 0, 4'd0};
    vecs[1]  = '{8'h55, 4'd3,  8'h51, 1'b1, 8'h55, 4'd1, 4'd0, 0, 4'd0};
    vecs[2]  = '{8'h55, 4'd5,  8'hD5, 1'b1, 8'h55, 4'd1, 4'd0, 0, 4'd0};
    vecs[3]  = '{8'h55, 4'd9,  8'h56, 1'b0, 8'h00, 4'd0, 4'd1, 1, 4'd9};
    vecs[4]  = '{8'h55, 4'd15, 8'h54, 1'b1, 8'h55, 4'd1, 4'd0, 0, 4'd0};
    vecs[5]  = '{8'h55, 4'd0,  8'h57, 1'b1, 8'h55, 4'd1, 4'd0, 0, 4'd0};
    vecs[6]  = '{8'h55, 4'd7,  8'h5D, 1'b1, 8'h55, 4'd1, 4'd0, 0, 4'd0};
    vecs[7]  = '{8'h55, 4'd12, 8'h05, 1'b0, 8'h00, 4'd0, 4'd1, 1, 4'd12};
    vecs[8]  = '{8'h00, 4'd2,  8'h40, 1'b1, 8'h00, 4'd1, 4'd0, 0, 4'd0};
    vecs[9]  = '{8'h00, 4'd10, 8'h80, 1'b1, 8'h00, 4'd1, 4'd0, 0, 4'd0};
    vecs[10] = '{8'h00, 4'd4,  8'h03, 1'b0, 8'h00, 4'd0, 4'd1, 1, 4'd4};

    repeat (3) @(negedge clk);
    check_zero("reset");
    check("reset.state", state_dbg, 0);
    rst_n = 1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Backpressure on the first read and on the write-back.
    load_mem(8'h55, 4'd3, 8'h51);
    exp_q.push_back({4'd3, 8'h55});
    stall_rd = 5; stall_wr = 5;
    pulse_start("bp");
    wait_done("bp", 400);
    check("bp.reads", rd_cnt, DEPTH);
    check("bp.pending_writes", exp_q.size(), 0);
    check("bp.corr", corr_cnt, 1);
    check("bp.stall_used", stall_rd + stall_wr, 0);

    // Every word corrupted: corr_cnt saturates at 2**CW-1.
    load_mem(8'h51, 4'd0, 8'h51);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({i[AW-1:0], 8'h55});
    pulse_start("sat");
    wait_done("sat", 600);
    check("sat.writes", wr_cnt, DEPTH);
    check("sat.corr", corr_cnt, 15);
    check("sat.uncorr", uncorr_cnt, 0);

    // start while busy must not restart or clear the counters.
    load_mem(8'h55, 4'd1, 8'h51);
    exp_q.push_back({4'd1, 8'h55});
    pulse_start("rebusy");
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (rd_cnt >= 8) begin hit = 1; break; end
    end
    check("rebusy.reached_mid", hit, 1);
    start = 1; @(negedge clk); start = 0;
    wait_done("rebusy", 400);
    check("rebusy.reads", rd_cnt, DEPTH);
    check("rebusy.corr", corr_cnt, 1);
    check("rebusy.pending_writes", exp_q.size(), 0);

    // Abort while the first read is still waiting for its grant.
    load_mem(8'h55, 4'd0, 8'h55);
    stall_rd = 100;
    pulse_start("ab_rdreq");
    repeat (2) @(negedge clk);
    abort = 1;
    wait_done("ab_rdreq", 20);
    abort = 0; stall_rd = 0;
    check("ab_rdreq.reads", rd_cnt, 0);

    // Abort while the read of address 6 is in flight: CHECK still counts, no write.
    load_mem(8'h55, 4'd6, 8'h51);
    pulse_start("ab_rdwait");
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (mem_rvalid && last_rd_addr == 4'd6) begin hit = 1; break; end
    end
    check("ab_rdwait.reached_addr6", hit, 1);
    abort = 1;
    wait_done("ab_rdwait", 20);
    abort = 0;
    check("ab_rdwait.reads", rd_cnt, 7);
    check("ab_rdwait.writes", wr_cnt, 0);
    check("ab_rdwait.corr", corr_cnt, 1);
    check("ab_rdwait.mem6", mem[6], 8'h51);

    // Reset while a write-back is held off by the memory.
    load_mem(8'h55, 4'd2, 8'h51);
    exp_q.push_back({4'd2, 8'h55});
    stall_wr = 50;
    pulse_start("rst_wr");
    hit = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk); #1;
      if (mem_req && mem_we) begin hit = 1; break; end
    end
    check("rst_wr.reached_wr", hit, 1);
    rst_n = 0;
    @(negedge clk); #1;
    check_zero("rst_wr");
    @(negedge clk);
    rst_n = 1; stall_wr = 0;
    exp_q.delete();
    check("rst_wr.mem2", mem[2], 8'h51);
    repeat (3) @(negedge clk);
    check("rst_wr.stays_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
